i2s_rx: RTL and testbench

- I2S receiver: the input end of the interface driven by the design's I2S transmitter (sck/lrck/data).
- Oversamples the serial lines on the system clock, deserialises standard I2S frames (MSB first, one-bit delay after lrck edge, lrck low = left), and presents left/right sample pairs on a valid/ready interface.
- Used for audio loopback self-test and as the capture path for an external I2S ADC.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_sync_edge.sv | 40 ++++
 rtl/i2s_rx.sv | 173 +++++++++++++++++
 tb/tb_i2s_rx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding, receiver states and default widths
// used by both the transmitter and the receiver.
package i2s_pkg;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  localparam int I2S_DATA_W = 16;
  localparam int I2S_SLOT_W = 32;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings sck/lrck/data into the clk domain and flags each sck rising edge,
// with lrck and data delivered on the same cycle as the edge strobe.
module i2s_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic lrck,
  input  logic data,
  output logic sck_rise,
  output logic lrck_sync,
  output logic data_sync
);

  logic [1:0] sck_ff;
  logic [1:0] lrck_ff;
  logic [1:0] data_ff;
  logic       sck_prev;

  // lrck/data get one extra stage so they stay aligned with the registered edge strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_ff    <= '0;
      lrck_ff   <= '0;
      data_ff   <= '0;
      sck_prev  <= 1'b0;
      sck_rise  <= 1'b0;
      lrck_sync <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      sck_ff    <= {sck_ff[0], sck};
      lrck_ff   <= {lrck_ff[0], lrck};
      data_ff   <= {data_ff[0], data};
      sck_prev  <= sck_ff[1];
      sck_rise  <= sck_ff[1] & ~sck_prev;
      lrck_sync <= lrck_ff[1];
      data_sync <= data_ff[1];
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises standard I2S frames (MSB first, one-bit delay,
// lrck low = left) and presents left/right pairs on a valid/ready interface.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i2s_sck,
  input  logic              i2s_lrck,
  input  logic              i2s_data,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              sck_rise;
  logic              lrck_s;
  logic              data_s;

  rx_state_t         state;
  rx_state_t         state_next;

  logic              lrck_prev;
  logic              lrck_chg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_step;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_step;
  logic [DATA_W-1:0] left_hold;
  logic              left_hold_valid;

  logic              pair_fire;
  logic [DATA_W-1:0] pair_left;
  logic [DATA_W-1:0] pair_right;

  logic              sync_start;
  logic              run_shift;
  logic              slot_end;
  logic              word_ok;
  logic              commit_left;
  logic              commit_right;
  logic              short_slot;

  i2s_sync_edge u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .sck       (i2s_sck),
    .lrck      (i2s_lrck),
    .data      (i2s_data),
    .sck_rise  (sck_rise),
    .lrck_sync (lrck_s),
    .data_sync (data_s)
  );

  assign lrck_chg = (lrck_s != lrck_prev);

  // Bits past DATA_W only advance the counter, which saturates at SLOT_W
  always_comb begin
    shift_step = shift_reg;
    cnt_step   = bit_cnt;
    if (bit_cnt < DATA_CNT) begin
      shift_step = {shift_reg[DATA_W-2:0], data_s};
      cnt_step   = bit_cnt + CNT_ONE;
    end else if (bit_cnt < SLOT_CNT) begin
      cnt_step   = bit_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (sck_rise && lrck_chg && lrck_prev == I2S_RIGHT) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = SYNC;
    endcase
  end

  always_comb begin
    sync_start = 1'b0;
    run_shift  = 1'b0;
    slot_end   = 1'b0;
    case (state)
      SYNC: sync_start = sck_rise && lrck_chg && lrck_prev == I2S_RIGHT;
      RUN: begin
        run_shift = sck_rise;
        slot_end  = sck_rise && lrck_chg;
      end
      default: ;
    endcase
  end

  // The edge that shows the lrck change still carries the old channel's last bit
  assign word_ok      = (cnt_step >= DATA_CNT);
  assign commit_left  = slot_end && word_ok && lrck_prev == I2S_LEFT;
  assign commit_right = slot_end && word_ok && lrck_prev == I2S_RIGHT;
  assign short_slot   = slot_end && !word_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lrck_prev       <= 1'b0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      left_hold       <= '0;
      left_hold_valid <= 1'b0;
      pair_fire       <= 1'b0;
      pair_left       <= '0;
      pair_right      <= '0;
    end else begin
      pair_fire <= 1'b0;
      if (sck_rise) lrck_prev <= lrck_s;
      if (sync_start || slot_end) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (run_shift) begin
        bit_cnt   <= cnt_step;
        shift_reg <= shift_step;
      end
      if (commit_left) begin
        left_hold       <= shift_step;
        left_hold_valid <= 1'b1;
      end
      if (commit_right && left_hold_valid) begin
        pair_fire       <= 1'b1;
        pair_left       <= left_hold;
        pair_right      <= shift_step;
        left_hold_valid <= 1'b0;
      end
      if (short_slot) left_hold_valid <= 1'b0;
    end
  end

  // Acceptance in the same cycle as a new pair frees the slot, so no overrun then
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (pair_fire && (!sample_valid || sample_ready)) begin
        left_data    <= pair_left;
        right_data   <= pair_right;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun   <= err_clr ? 1'b0 : (overrun | (pair_fire && sample_valid && !sample_ready));
      frame_err <= err_clr ? 1'b0 : (frame_err | short_slot);
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives I2S frames at sck = clk/8 into a
// 16/16 and a 24/32 instance and compares against a slot-level model.
module tb_i2s_rx;
  import i2s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, i2s_sck, i2s_lrck, i2s_data, sample_ready, err_clr;
  logic [15:0] l16, r16;
  logic        v16, ov16, fe16;
  logic [23:0] l24, r24;
  logic        v24, ov24, fe24;

  i2s_rx #(.DATA_W(16), .SLOT_W(16)) u16 (
    .clk(clk), .reset_n(reset_n), .i2s_sck(i2s_sck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .left_data(l16), .right_data(r16), .sample_valid(v16), .sample_ready(sample_ready),
    .overrun(ov16), .frame_err(fe16), .err_clr(err_clr)
  );

  i2s_rx #(.DATA_W(24), .SLOT_W(32)) u24 (
    .clk(clk), .reset_n(reset_n), .i2s_sck(i2s_sck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .left_data(l24), .right_data(r24), .sample_valid(v24), .sample_ready(sample_ready),
    .overrun(ov24), .frame_err(fe24), .err_clr(err_clr)
  );

  int          checks = 0;
  int          passed = 0;
  int          clk_count = 0;
  int          last_rise_count = 0;
  logic        carry = 1'b0;
  logic        sv16_prev = 1'b0;
  logic [63:0] rx16_q[$];
  logic [63:0] rx24_q[$];
  logic [63:0] exp_q[$];
  int          lat16_q[$];
  logic        slot_ch[$];
  int          slot_len[$];
  logic [31:0] slot_word[$];
  logic        exp_err;

  always @(posedge clk) clk_count = clk_count + 1;

  // Record every accepted pair and the clk distance from the last pad sck rise
  always @(negedge clk) begin
    if (v16 && sample_ready) rx16_q.push_back({32'(l16), 32'(r16)});
    if (v24 && sample_ready) rx24_q.push_back({32'(l24), 32'(r24)});
    if (v16 && !sv16_prev) lat16_q.push_back(clk_count - last_rise_count);
    sv16_prev = v16;
  end

  task automatic drive_period(input logic lr, input logic b);
    i2s_sck  = 1'b0;
    i2s_lrck = lr;
    i2s_data = carry;
    carry    = b;
    #40;
    i2s_sck = 1'b1;
    last_rise_count = clk_count;
    #40;
  endtask

  task automatic push_slot(input logic ch, input logic [31:0] word, input int len);
    slot_ch.push_back(ch);
    slot_len.push_back(len);
    slot_word.push_back(word);
    for (int k = len - 1; k >= 0; k--) drive_period(ch, word[k]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; i2s_sck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0;
    carry = 1'b0; sample_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rx16_q.delete(); rx24_q.delete(); lat16_q.delete();
    slot_ch.delete(); slot_len.delete(); slot_word.delete();
  endtask

  // Slot-level reference: sync on the first right->left change, then pair each
  // complete left slot with the following complete right slot.
  task automatic model_pairs(input int dw);
    logic [31:0] hold, w, mask;
    logic        have, started;
    exp_q.delete();
    exp_err = 1'b0; have = 1'b0; started = 1'b0; hold = '0;
    mask = 32'((64'd1 << dw) - 64'd1);
    for (int i = 0; i < slot_ch.size() - 1; i++) begin
      if (!started && i > 0 && slot_ch[i] == I2S_LEFT && slot_ch[i-1] == I2S_RIGHT) started = 1'b1;
      if (started) begin
        if (slot_len[i] < dw) begin
          exp_err = 1'b1;
          have = 1'b0;
        end else begin
          w = (slot_word[i] >> (slot_len[i] - dw)) & mask;
          if (slot_ch[i] == I2S_LEFT) begin
            hold = w;
            have = 1'b1;
          end else if (have) begin
            exp_q.push_back({hold, w});
            have = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i2s_sck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0;
    sample_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (l16 !== 16'h0) $display("[TB] FAIL reset_left16: got %h expected 0", l16); else passed++;
    checks++; if (r16 !== 16'h0) $display("[TB] FAIL reset_right16: got %h expected 0", r16); else passed++;
    checks++; if (v16 !== 1'b0) $display("[TB] FAIL reset_valid16: got %b expected 0", v16); else passed++;
    checks++; if (ov16 !== 1'b0) $display("[TB] FAIL reset_overrun16: got %b expected 0", ov16); else passed++;
    checks++; if (fe16 !== 1'b0) $display("[TB] FAIL reset_frame_err16: got %b expected 0", fe16); else passed++;
    checks++; if ({l24, r24, v24, ov24, fe24} !== 51'h0)
      $display("[TB] FAIL reset_all24: got %h expected 0", {l24, r24, v24, ov24, fe24}); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_basic16();
    do_reset();
    push_slot(I2S_RIGHT, 32'($urandom), 16);
    push_slot(I2S_LEFT, 32'hA5A5, 16);
    push_slot(I2S_RIGHT, 32'h5A5A, 16);
    for (int f = 0; f < 3; f++) begin
      push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
      push_slot(I2S_RIGHT, 32'($urandom_range(0, 65535)), 16);
    end
    push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
    repeat (10) @(posedge clk);
    #1;
    model_pairs(16);
    checks++; if (rx16_q.size() !== exp_q.size())
      $display("[TB] FAIL basic_count: got %0d expected %0d", rx16_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [63:0] got;
      got = (i < rx16_q.size()) ? rx16_q[i] : 64'hx;
      checks++; if (got !== exp_q[i]) $display("[TB] FAIL basic_pair%0d: got %h expected %h", i, got, exp_q[i]); else passed++;
    end
    for (int i = 0; i < lat16_q.size(); i++) begin
      checks++; if (lat16_q[i] !== 5) $display("[TB] FAIL basic_latency%0d: got %0d expected 5", i, lat16_q[i]); else passed++;
    end
    checks++; if (fe16 !== 1'b0 || ov16 !== 1'b0) $display("[TB] FAIL basic_flags: got %b%b expected 00", fe16, ov16); else passed++;
  endtask

  task automatic test_wide24();
    do_reset();
    push_slot(I2S_RIGHT, $urandom, 32);
    push_slot(I2S_LEFT, 32'h123456FF, 32);
    push_slot(I2S_RIGHT, {24'hABCDEF, 8'($urandom)}, 32);
    for (int f = 0; f < 2; f++) begin
      push_slot(I2S_LEFT, $urandom, 32);
      push_slot(I2S_RIGHT, $urandom, 32);
    end
    push_slot(I2S_LEFT, $urandom, 32);
    repeat (10) @(posedge clk);
    #1;
    model_pairs(24);
    checks++; if (rx24_q.size() !== exp_q.size())
      $display("[TB] FAIL wide24_count: got %0d expected %0d", rx24_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [63:0] got;
      got = (i < rx24_q.size()) ? rx24_q[i] : 64'hx;
      checks++; if (got !== exp_q[i]) $display("[TB] FAIL wide24_pair%0d: got %h expected %h", i, got, exp_q[i]); else passed++;
    end
    checks++; if (fe24 !== exp_err) $display("[TB] FAIL wide24_frame_err: got %b expected %b", fe24, exp_err); else passed++;
    model_pairs(16);
    checks++; if (rx16_q.size() !== exp_q.size())
      $display("[TB] FAIL sat16_count: got %0d expected %0d", rx16_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [63:0] got;
      got = (i < rx16_q.size()) ? rx16_q[i] : 64'hx;
      checks++; if (got !== exp_q[i]) $display("[TB] FAIL sat16_pair%0d: got %h expected %h", i, got, exp_q[i]); else passed++;
    end
    checks++; if (fe16 !== exp_err) $display("[TB] FAIL sat16_frame_err: got %b expected %b", fe16, exp_err); else passed++;
  endtask

  task automatic test_midstart();
    do_reset();
    push_slot(I2S_LEFT, $urandom, 5);
    push_slot(I2S_RIGHT, $urandom, 7);
    checks++; if (rx16_q.size() !== 0 || v16 !== 1'b0)
      $display("[TB] FAIL midstart_garbage: got %0d pairs expected 0", rx16_q.size()); else passed++;
    push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
    checks++; if (rx16_q.size() !== 0)
      $display("[TB] FAIL midstart_early: got %0d pairs expected 0", rx16_q.size()); else passed++;
    push_slot(I2S_RIGHT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_RIGHT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
    repeat (10) @(posedge clk);
    #1;
    model_pairs(16);
    checks++; if (rx16_q.size() !== exp_q.size())
      $display("[TB] FAIL midstart_count: got %0d expected %0d", rx16_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [63:0] got;
      got = (i < rx16_q.size()) ? rx16_q[i] : 64'hx;
      checks++; if (got !== exp_q[i]) $display("[TB] FAIL midstart_pair%0d: got %h expected %h", i, got, exp_q[i]); else passed++;
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    push_slot(I2S_RIGHT, $urandom, 16);
    push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_RIGHT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_LEFT, 32'($urandom_range(0, 1023)), 10);
    push_slot(I2S_RIGHT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_RIGHT, 32'($urandom_range(0, 65535)), 16);
    push_slot(I2S_LEFT, 32'($urandom_range(0, 65535)), 16);
    repeat (10) @(posedge clk);
    #1;
    model_pairs(16);
    checks++; if (rx16_q.size() !== exp_q.size())
      $display("[TB] FAIL ferr_count: got %0d expected %0d", rx16_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [63:0] got;
      got = (i < rx16_q.size()) ? rx16_q[i] : 64'hx;
      checks++; if (got !== exp_q[i]) $display("[TB] FAIL ferr_pair%0d: got %h expected %h", i, got, exp_q[i]); else passed++;
    end
    checks++; if (fe16 !== exp_err) $display("[TB] FAIL ferr_flag: got %b expected %b", fe16, exp_err); else passed++;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checks++; if (fe16 !== 1'b0) $display("[TB] FAIL ferr_clear: got %b expected 0", fe16); else passed++;
    checks++; if (ov16 !== 1'b0) $display("[TB] FAIL ferr_overrun: got %b expected 0", ov16); else passed++;
  endtask

  task automatic test_overrun();
    logic [15:0] a, b, c, d, e, f;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    d = 16'($urandom); e = 16'($urandom); f = 16'($urandom);
    do_reset();
    sample_ready = 1'b0;
    push_slot(I2S_RIGHT, $urandom, 16);
    push_slot(I2S_LEFT, 32'(a), 16);
    push_slot(I2S_RIGHT, 32'(b), 16);
    push_slot(I2S_LEFT, 32'(c), 16);
    push_slot(I2S_RIGHT, 32'(d), 16);
    fork
      begin
        push_slot(I2S_LEFT, 32'(e), 16);
        push_slot(I2S_RIGHT, 32'(f), 16);
        push_slot(I2S_LEFT, $urandom, 16);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        checks++; if (v16 !== 1'b1) $display("[TB] FAIL ovr_valid_held: got %b expected 1", v16); else passed++;
        checks++; if ({l16, r16} !== {a, b}) $display("[TB] FAIL ovr_pair_kept: got %h expected %h", {l16, r16}, {a, b}); else passed++;
        checks++; if (ov16 !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", ov16); else passed++;
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (v16 !== 1'b0) $display("[TB] FAIL ovr_consumed: got %b expected 0", v16); else passed++;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx16_q.size() !== 2) $display("[TB] FAIL ovr_count: got %0d expected 2", rx16_q.size()); else passed++;
    checks++; if (rx16_q.size() < 2 || rx16_q[1] !== {16'h0, e, 16'h0, f})
      $display("[TB] FAIL ovr_next_pair: got %0d entries expected pair %h", rx16_q.size(), {e, f}); else passed++;
    checks++; if (ov16 !== 1'b1) $display("[TB] FAIL ovr_sticky: got %b expected 1", ov16); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] a, b, e, f;
    a = 16'($urandom_range(1, 65535)); b = 16'($urandom); e = 16'($urandom); f = 16'($urandom);
    do_reset();
    push_slot(I2S_RIGHT, $urandom, 16);
    push_slot(I2S_LEFT, 32'(a), 16);
    push_slot(I2S_RIGHT, 32'(b), 16);
    fork
      begin
        push_slot(I2S_LEFT, $urandom, 16);
        push_slot(I2S_RIGHT, $urandom, 16);
        push_slot(I2S_LEFT, 32'(e), 16);
        push_slot(I2S_RIGHT, 32'(f), 16);
        push_slot(I2S_LEFT, $urandom, 16);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        checks++; if (l16 !== a) $display("[TB] FAIL rstmid_before: got %h expected %h", l16, a); else passed++;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({l16, r16, v16, ov16, fe16} !== 35'h0)
          $display("[TB] FAIL rstmid_outputs: got %h expected 0", {l16, r16, v16, ov16, fe16}); else passed++;
        reset_n = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rx16_q.size() !== 2) $display("[TB] FAIL rstmid_count: got %0d expected 2", rx16_q.size()); else passed++;
    checks++; if (rx16_q.size() < 2 || rx16_q[1] !== {16'h0, e, 16'h0, f})
      $display("[TB] FAIL rstmid_resume: got %0d entries expected pair %h", rx16_q.size(), {e, f}); else passed++;
    checks++; if (fe16 !== 1'b0) $display("[TB] FAIL rstmid_frame_err: got %b expected 0", fe16); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic16();
    test_wide24();
    test_midstart();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
